fwrisc_regfile_dbg: RTL and testbench

Debug access engine that drives the register-file port set (read address, 1-cycle-latency read data, write address/data/enable) from a byte-serial command stream, normally the UART receiver. It parses read/write commands, halts the core via a request/acknowledge handshake, performs the register access, and returns a response byte stream to the UART transmitter. It sits between the UART byte interfaces and a dedicated port set on the 64-entry register file.

---
 rtl/fwrisc_regfile_dbg_if.sv | 30 +++
 rtl/fwrisc_regfile_dbg.sv | 124 ++++++++++++
 tb/tb_fwrisc_regfile_dbg.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fwrisc_regfile_dbg_if.sv
// Byte-stream, halt handshake and register-file port bundle for the debug engine.
// The master side belongs to the engine; the slave side to the UART, core and register file.
interface fwrisc_regfile_dbg_if #(
    parameter int NREGS_LOG2 = 6
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  halt_req;
    logic                  halted;
    logic [NREGS_LOG2-1:0] rf_raddr;
    logic [31:0]           rf_rdata;
    logic [NREGS_LOG2-1:0] rf_waddr;
    logic [31:0]           rf_wdata;
    logic                  rf_wen;
    logic                  busy;

    modport master (
        input  rx_data, rx_valid, tx_ready, halted, rf_rdata,
        output rx_ready, tx_data, tx_valid, halt_req, rf_raddr, rf_waddr, rf_wdata, rf_wen, busy
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, halted, rf_rdata,
        input  rx_ready, tx_data, tx_valid, halt_req, rf_raddr, rf_waddr, rf_wdata, rf_wen, busy
    );
endinterface

// File: rtl/fwrisc_regfile_dbg.sv
// Debug engine: parses byte-serial read/write commands, halts the core, accesses the
// register file and streams the response bytes back.
module fwrisc_regfile_dbg #(
    parameter int         NREGS_LOG2 = 6,
    parameter logic [7:0] ACK_BYTE   = 8'hA5,
    parameter logic [7:0] ERR_BYTE   = 8'hEE
) (
    input logic clock,
    input logic reset,
    fwrisc_regfile_dbg_if.master dbg
);
    typedef enum logic [2:0] {
        IDLE, DATA, HALT, ACCESS, RDWAIT, SEND, ACK, ERR
    } state_t;

    state_t                state, state_nxt;
    logic [NREGS_LOG2-1:0] addr;
    logic                  is_wr;
    logic [31:0]           wdata;
    logic [31:0]           shift;
    logic [1:0]            cnt;

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        dbg.rx_ready = 1'b0;
        dbg.tx_valid = 1'b0;
        dbg.tx_data  = '0;
        dbg.halt_req = 1'b0;
        dbg.rf_wen   = 1'b0;
        dbg.busy     = (state != IDLE);
        case (state)
            IDLE: begin
                dbg.rx_ready = 1'b1;
                if (dbg.rx_valid) begin
                    if (dbg.rx_data[6])      state_nxt = ERR;
                    else if (dbg.rx_data[7]) state_nxt = DATA;
                    else                     state_nxt = HALT;
                end
            end
            DATA: begin
                dbg.rx_ready = 1'b1;
                if (dbg.rx_valid && cnt == 2'd3) state_nxt = HALT;
            end
            HALT: begin
                dbg.halt_req = 1'b1;
                if (dbg.halted) state_nxt = ACCESS;
            end
            ACCESS: begin
                dbg.halt_req = 1'b1;
                dbg.rf_wen   = is_wr;
                state_nxt    = is_wr ? ACK : RDWAIT;
            end
            RDWAIT: begin
                dbg.halt_req = 1'b1;
                state_nxt    = SEND;
            end
            SEND: begin
                dbg.tx_valid = 1'b1;
                dbg.tx_data  = shift[7:0];
                if (dbg.tx_ready && cnt == 2'd3) state_nxt = IDLE;
            end
            ACK: begin
                dbg.tx_valid = 1'b1;
                dbg.tx_data  = ACK_BYTE;
                if (dbg.tx_ready) state_nxt = IDLE;
            end
            ERR: begin
                dbg.tx_valid = 1'b1;
                dbg.tx_data  = ERR_BYTE;
                if (dbg.tx_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Outputs are held low for the whole reset assertion, not just after the first edge
        if (!reset) begin
            dbg.rx_ready = 1'b0;
            dbg.tx_valid = 1'b0;
            dbg.tx_data  = '0;
            dbg.halt_req = 1'b0;
            dbg.rf_wen   = 1'b0;
            dbg.busy     = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            addr  <= '0;
            is_wr <= 1'b0;
            wdata <= '0;
            shift <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (dbg.rx_valid) begin
                    addr  <= dbg.rx_data[NREGS_LOG2-1:0];
                    is_wr <= dbg.rx_data[7];
                    cnt   <= '0;
                end
                DATA: if (dbg.rx_valid) begin
                    wdata <= {dbg.rx_data, wdata[31:8]};
                    cnt   <= cnt + 2'd1;
                end
                RDWAIT: begin
                    shift <= dbg.rf_rdata;
                    cnt   <= '0;
                end
                SEND: if (dbg.tx_ready) begin
                    shift <= {8'h00, shift[31:8]};
                    cnt   <= cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign dbg.rf_raddr = reset ? addr  : '0;
    assign dbg.rf_waddr = reset ? addr  : '0;
    assign dbg.rf_wdata = reset ? wdata : '0;
endmodule

// File: tb/tb_fwrisc_regfile_dbg.sv
// Directed bench for fwrisc_regfile_dbg with a small register-file model (x0 reads as zero).
module tb_fwrisc_regfile_dbg;
    logic clock = 1'b0;
    logic reset;

    fwrisc_regfile_dbg_if #(.NREGS_LOG2(6)) ifc ();

    fwrisc_regfile_dbg #(.NREGS_LOG2(6), .ACK_BYTE(8'hA5), .ERR_BYTE(8'hEE)) dut (
        .clock (clock),
        .reset (reset),
        .dbg   (ifc.master)
    );

    always #5 clock = ~clock;

    logic [31:0] mem [64];
    logic        load_en = 1'b0;
    logic [5:0]  load_addr = '0;
    logic [31:0] load_data = '0;
    int          wen_cnt = 0;
    int          halt_cnt = 0;
    logic [5:0]  last_waddr = '0;
    logic [31:0] last_wdata = '0;

    always @(posedge clock) begin
        if (load_en) mem[load_addr] <= load_data;
        else if (ifc.rf_wen && ifc.rf_waddr != 6'd0) mem[ifc.rf_waddr] <= ifc.rf_wdata;
        ifc.rf_rdata <= (ifc.rf_raddr == 6'd0) ? 32'h0 : mem[ifc.rf_raddr];
        if (ifc.rf_wen) begin
            wen_cnt    <= wen_cnt + 1;
            last_waddr <= ifc.rf_waddr;
            last_wdata <= ifc.rf_wdata;
        end
        if (ifc.halt_req) halt_cnt <= halt_cnt + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clock);
        load_en = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte transfers.
    task automatic send_byte(input logic [7:0] b);
        int n;
        ifc.rx_data  = b;
        ifc.rx_valid = 1'b1;
        n = 0;
        while (!ifc.rx_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!ifc.rx_ready) check("rx_timeout", 64'd0, 64'd1);
        else begin
            @(posedge clock);
            @(negedge clock);
        end
        ifc.rx_valid = 1'b0;
    endtask

    task automatic recv_byte(input string tag, input logic [7:0] exp);
        int n;
        ifc.tx_ready = 1'b1;
        n = 0;
        while (!ifc.tx_valid && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!ifc.tx_valid) check({tag, "_timeout"}, 64'd0, 64'd1);
        else begin
            check(tag, 64'(ifc.tx_data), 64'(exp));
            @(posedge clock);
            @(negedge clock);
        end
        ifc.tx_ready = 1'b0;
    endtask

    task automatic recv_word(input string tag, input logic [31:0] exp);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] eb;
            eb = exp[8*i +: 8];
            recv_byte($sformatf("%s_b%0d", tag, i), eb);
        end
    endtask

    function automatic logic [63:0] out_vec();
        return 64'({ifc.rx_ready, ifc.tx_valid, ifc.tx_data, ifc.halt_req, ifc.rf_wen,
                    ifc.rf_raddr, ifc.rf_waddr, ifc.rf_wdata, ifc.busy});
    endfunction

    initial begin
        int w0;
        int h0;
        logic ok;
        reset = 1'b0;
        ifc.rx_valid = 1'b0;
        ifc.rx_data  = '0;
        ifc.tx_ready = 1'b0;
        ifc.halted   = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            preload(6'(i), 32'h0);
        end
        check("reset_outputs", out_vec(), 64'd0);
        reset = 1'b1;
        #1 check("rx_ready_after_reset", 64'(ifc.rx_ready), 64'd1);
        @(negedge clock);

        // Write reg 5 = 0x12345678, checking the write latency cycle by cycle
        w0 = wen_cnt;
        send_byte(8'h85); send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        check("wr_halt_n1", 64'({ifc.halt_req, ifc.rf_wen, ifc.rx_ready}), 64'b100);
        @(negedge clock);
        check("wr_wen_n2", 64'({ifc.rf_wen, ifc.rf_waddr, ifc.rf_wdata}), 64'({1'b1, 6'd5, 32'h12345678}));
        @(negedge clock);
        check("wr_ack_n3", 64'({ifc.tx_valid, ifc.tx_data, ifc.halt_req}), 64'({1'b1, 8'hA5, 1'b0}));
        recv_byte("wr_ack", 8'hA5);
        check("wr_wen_count", 64'(wen_cnt - w0), 64'd1);

        // Read reg 5 back with the read latency checked
        send_byte(8'h05);
        check("rd_halt_n1", 64'({ifc.halt_req, ifc.tx_valid}), 64'b10);
        @(negedge clock);
        check("rd_raddr_n2", 64'({ifc.halt_req, ifc.rf_raddr}), 64'({1'b1, 6'd5}));
        @(negedge clock);
        check("rd_rdwait_n3", 64'({ifc.halt_req, ifc.tx_valid}), 64'b10);
        @(negedge clock);
        check("rd_send_n4", 64'({ifc.tx_valid, ifc.tx_data, ifc.halt_req}), 64'({1'b1, 8'h78, 1'b0}));
        recv_word("rd5", 32'h12345678);

        // Halt stall on a read of reg 3
        preload(6'd3, 32'h0BADF00D);
        ifc.halted = 1'b0;
        w0 = wen_cnt;
        send_byte(8'h03);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!ifc.halt_req || ifc.tx_valid || ifc.rf_wen) ok = 1'b0;
            @(negedge clock);
        end
        check("stall_held", 64'(ok), 64'd1);
        ifc.halted = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("stall_no_tx_n2", 64'({ifc.tx_valid, ifc.halt_req}), 64'b01);
        @(negedge clock);
        check("stall_tx_n3", 64'({ifc.tx_valid, ifc.tx_data}), 64'({1'b1, 8'h0D}));
        recv_word("rd3", 32'h0BADF00D);
        check("stall_no_wen", 64'(wen_cnt - w0), 64'd0);

        // Reserved bit in header
        w0 = wen_cnt;
        h0 = halt_cnt;
        send_byte(8'h45);
        recv_byte("err_byte", 8'hEE);
        check("err_no_halt", 64'(halt_cnt - h0), 64'd0);
        check("err_no_wen", 64'(wen_cnt - w0), 64'd0);

        // Back-pressure on a read of reg 63
        preload(6'd63, 32'hDEADBEEF);
        send_byte(8'h3F);
        repeat (3) @(negedge clock);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!ifc.tx_valid || ifc.tx_data != 8'hEF || ifc.rx_ready) ok = 1'b0;
            @(negedge clock);
        end
        check("bp_held", 64'(ok), 64'd1);
        recv_word("rd63", 32'hDEADBEEF);

        // Reset in the middle of a write
        w0 = wen_cnt;
        send_byte(8'h8A); send_byte(8'h11); send_byte(8'h22);
        reset = 1'b0;
        #1 check("midrst_immediate", out_vec(), 64'd0);
        @(negedge clock);
        @(negedge clock);
        check("midrst_outputs", out_vec(), 64'd0);
        reset = 1'b1;
        #1 check("midrst_idle", 64'({ifc.rx_ready, ifc.busy}), 64'b10);
        @(negedge clock);
        check("midrst_no_wen", 64'(wen_cnt - w0), 64'd0);
        send_byte(8'h8A); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        recv_byte("rewr_ack", 8'hA5);
        check("rewr_wen", 64'({6'(wen_cnt - w0), last_waddr, last_wdata}), 64'({6'd1, 6'd10, 32'h04030201}));
        send_byte(8'h0A);
        recv_word("rd10", 32'h04030201);

        // Address 0
        w0 = wen_cnt;
        send_byte(8'h80); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
        recv_byte("wr0_ack", 8'hA5);
        check("wr0_wen", 64'({6'(wen_cnt - w0), last_waddr, last_wdata}), 64'({6'd1, 6'd0, 32'hFFFFFFFF}));
        send_byte(8'h00);
        recv_word("rd0", 32'h00000000);
        check("final_idle", 64'({ifc.busy, ifc.halt_req, ifc.rx_ready}), 64'b001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
